// File: rtl/uart_boot_loader.sv
// Framed UART program loader: SYNC, 16-bit word count, little-endian payload, XOR checksum.
// Writes each word to instruction memory and holds the core in reset until a good load.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [7:0]    chk;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      chk          <= '0;
      timer        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (rx_dv) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        timer <= '0;
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_byte == SYNC_BYTE) begin
              state        <= S_LEN_LO;
              busy         <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              cpu_reset    <= 1'b1;
              words_loaded <= '0;
              chk          <= '0;
              byte_idx     <= '0;
              mem_addr     <= '0;
            end
          end
          S_LEN_LO: begin
            len[7:0] <= rx_byte;
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len[15:8] <= rx_byte;
            if ({rx_byte, len[7:0]} == 16'd0 || {1'b0, rx_byte, len[7:0]} > MAX_WORDS) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            chk      <= chk ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_byte;
              2'd1: word_buf[15:8]  <= rx_byte;
              2'd2: word_buf[23:16] <= rx_byte;
              default: begin
                mem_we       <= 1'b1;
                mem_din      <= {rx_byte, word_buf};
                mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                words_loaded <= words_loaded + 16'd1;
                if (words_loaded + 16'd1 == len) state <= S_CHECK;
              end
            endcase
          end
          S_CHECK: begin
            busy <= 1'b0;
            if (rx_byte == chk) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (busy) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timer <= '0;
          state <= S_ERROR;
          busy  <= 1'b0;
          error <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule
